// File: rtl/sdram_char_writer_if.sv
// Request channel for sdram_char_writer: a valid/ready handshake carrying
// character position, glyph code and foreground/background colours.
// The master pushes requests; the slave (the writer) returns req_ready.
interface sdram_char_writer_if #(
  parameter int CODE_W  = 7,
  parameter int COLOR_W = 3
);
  logic               req_valid;
  logic               req_ready;
  logic [6:0]         req_col;
  logic [6:0]         req_row;
  logic [CODE_W-1:0]  req_code;
  logic [COLOR_W-1:0] req_fg;
  logic [COLOR_W-1:0] req_bg;

  modport master (
    output req_valid, req_col, req_row, req_code, req_fg, req_bg,
    input  req_ready
  );

  modport slave (
    input  req_valid, req_col, req_row, req_code, req_fg, req_bg,
    output req_ready
  );
endinterface

// File: rtl/sdram_char_writer.sv
// Queued 8x8 glyph renderer for the SDRAM frame buffer.
// Requests are buffered in a small FIFO. Each glyph is written row by row
// as PRECHARGE / ACTIVE / 8x WRITE / PRECHARGE, only while win_en marks the
// SDRAM bus as free. Rendering pauses between rows when the window closes
// and resumes at the same glyph row. No SDRAM row is ever left open.
// Optional build macro CHAR_BG_FILL_EN: when defined, clear pixels are
// written with the request's background colour instead of zero.
module sdram_char_writer #(
  parameter int FIFO_DEPTH = 4,
  parameter int CODE_W     = 7,
  parameter int COLOR_W    = 3
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              win_en,
  sdram_char_writer_if.slave req,
  output logic [CODE_W+2:0] font_addr,
  input  logic [7:0]        font_data,
  output logic [15:0]       D_SDRAM,
  output logic [11:0]       A_SDRAM,
  output logic [1:0]        B_SDRAM,
  output logic              CSn_SDRAM,
  output logic              RASn_SDRAM,
  output logic              CASn_SDRAM,
  output logic              WEn_SDRAM,
  output logic              mx_en_char,
  output logic              busy,
  output logic              glyph_done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [3:0] CMD_NOP = 4'b1111;
  localparam logic [3:0] CMD_PRE = 4'b0010;
  localparam logic [3:0] CMD_ACT = 4'b0011;
  localparam logic [3:0] CMD_WR  = 4'b0100;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PRE0  = 3'd1;
  localparam logic [2:0] ST_ACT   = 3'd2;
  localparam logic [2:0] ST_WR    = 3'd3;
  localparam logic [2:0] ST_PREN  = 3'd4;
  localparam logic [2:0] ST_PAUSE = 3'd5;

  logic [2:0] state;
  logic [2:0] gx;
  logic [2:0] gy;

  logic [6:0]         col;
  logic [6:0]         row;
  logic [CODE_W-1:0]  code;
  logic [COLOR_W-1:0] fg;

  logic [6:0]         fifo_col  [FIFO_DEPTH];
  logic [6:0]         fifo_row  [FIFO_DEPTH];
  logic [CODE_W-1:0]  fifo_code [FIFO_DEPTH];
  logic [COLOR_W-1:0] fifo_fg   [FIFO_DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;

  logic fifo_full;
  logic fifo_empty;
  logic push;
  logic pop;
  logic start;

  logic [3:0]  cmd;
  logic        pix;
  logic [15:0] set_data;
  logic [15:0] clear_data;

`ifdef CHAR_BG_FILL_EN
  logic [COLOR_W-1:0] bg;
  logic [COLOR_W-1:0] fifo_bg [FIFO_DEPTH];
`else
  logic unused_bg;
  assign unused_bg = ^req.req_bg;
`endif

  assign fifo_full  = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign req.req_ready = !fifo_full;
  assign push  = req.req_valid && !fifo_full;
  assign start = (state == ST_IDLE) && !fifo_empty && win_en;
  assign pop   = start;

  // FIFO storage: written on every accepted request, no reset needed
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_col[wr_ptr]  <= req.req_col;
      fifo_row[wr_ptr]  <= req.req_row;
      fifo_code[wr_ptr] <= req.req_code;
      fifo_fg[wr_ptr]   <= req.req_fg;
`ifdef CHAR_BG_FILL_EN
      fifo_bg[wr_ptr]   <= req.req_bg;
`endif
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Latch the FIFO head into the working registers when a glyph starts
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      col  <= '0;
      row  <= '0;
      code <= '0;
      fg   <= '0;
`ifdef CHAR_BG_FILL_EN
      bg   <= '0;
`endif
    end else if (start) begin
      col  <= fifo_col[rd_ptr];
      row  <= fifo_row[rd_ptr];
      code <= fifo_code[rd_ptr];
      fg   <= fifo_fg[rd_ptr];
`ifdef CHAR_BG_FILL_EN
      bg   <= fifo_bg[rd_ptr];
`endif
    end
  end

  // Glyph sequencer: rows always finish through PREN, pausing only between rows
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state      <= ST_IDLE;
      gx         <= '0;
      gy         <= '0;
      glyph_done <= 1'b0;
    end else begin
      glyph_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            gy    <= '0;
            state <= ST_PRE0;
          end
        end
        ST_PRE0: state <= ST_ACT;
        ST_ACT: begin
          gx    <= '0;
          state <= ST_WR;
        end
        ST_WR: begin
          gx <= gx + 1'b1;
          if (gx == 3'd7) state <= ST_PREN;
        end
        ST_PREN: begin
          gy <= gy + 1'b1;
          if (gy == 3'd7) begin
            glyph_done <= 1'b1;
            state      <= ST_IDLE;
          end else if (!win_en) begin
            state <= ST_PAUSE;
          end else begin
            state <= ST_ACT;
          end
        end
        ST_PAUSE: begin
          if (win_en) state <= ST_PRE0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign font_addr  = {code, gy};
  assign pix        = font_data[3'd7 - gx];
  assign set_data   = 16'(fg);
`ifdef CHAR_BG_FILL_EN
  assign clear_data = 16'(bg);
`else
  assign clear_data = 16'h0000;
`endif

  // Decode the SDRAM command, address, bank and data from the sequencer state
  always_comb begin
    cmd        = CMD_NOP;
    A_SDRAM    = 12'h000;
    B_SDRAM    = 2'b00;
    D_SDRAM    = 16'h0000;
    mx_en_char = 1'b0;
    case (state)
      ST_PRE0, ST_PREN: begin
        cmd        = CMD_PRE;
        A_SDRAM    = 12'h400;
        B_SDRAM    = col[6:5];
        mx_en_char = 1'b1;
      end
      ST_ACT: begin
        cmd        = CMD_ACT;
        A_SDRAM    = {2'b00, row, gy};
        B_SDRAM    = col[6:5];
        mx_en_char = 1'b1;
      end
      ST_WR: begin
        cmd        = CMD_WR;
        A_SDRAM    = {4'b0000, col[4:0], gx};
        B_SDRAM    = col[6:5];
        D_SDRAM    = pix ? set_data : clear_data;
        mx_en_char = 1'b1;
      end
      default: ;
    endcase
  end

  assign {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM} = cmd;
  assign busy = !fifo_empty || (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_char_writer.sv
// Scoreboard bench for sdram_char_writer. Each accepted request pushes its
// full expected command stream; a negedge monitor pops and compares every
// non-NOP command and the glyph_done pulse.
module tb_sdram_char_writer;

  localparam int CODE_W  = 7;
  localparam int COLOR_W = 3;

  localparam logic [3:0] NOP = 4'b1111;
  localparam logic [3:0] PRE = 4'b0010;
  localparam logic [3:0] ACT = 4'b0011;
  localparam logic [3:0] WRC = 4'b0100;

  typedef struct {
    logic [3:0]  cmd;
    logic [11:0] a;
    logic [1:0]  b;
    logic [15:0] d;
    bit          last;
  } exp_t;

  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  logic win_en = 1'b0;
  logic [CODE_W+2:0] font_addr;
  logic [7:0]  font_data;
  logic [15:0] D_SDRAM;
  logic [11:0] A_SDRAM;
  logic [1:0]  B_SDRAM;
  logic CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM;
  logic mx_en_char, busy, glyph_done;

  exp_t expq[$];
  int checks = 0;
  int failures = 0;
  int nonnop = 0;
  int done_cnt = 0;
  bit prev_last = 1'b0;
  exp_t mon_e;
  logic [3:0] mon_cmd;

  sdram_char_writer_if #(.CODE_W(CODE_W), .COLOR_W(COLOR_W)) req_if ();

  sdram_char_writer #(.FIFO_DEPTH(4), .CODE_W(CODE_W), .COLOR_W(COLOR_W)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .win_en     (win_en),
    .req        (req_if),
    .font_addr  (font_addr),
    .font_data  (font_data),
    .D_SDRAM    (D_SDRAM),
    .A_SDRAM    (A_SDRAM),
    .B_SDRAM    (B_SDRAM),
    .CSn_SDRAM  (CSn_SDRAM),
    .RASn_SDRAM (RASn_SDRAM),
    .CASn_SDRAM (CASn_SDRAM),
    .WEn_SDRAM  (WEn_SDRAM),
    .mx_en_char (mx_en_char),
    .busy       (busy),
    .glyph_done (glyph_done)
  );

  always #5 CLK = ~CLK;

  // Asynchronous font ROM: glyph 0x41 is all 0x81 rows, others a mixed pattern
  function automatic logic [7:0] rom(input logic [9:0] a);
    if (a[9:3] == 7'h41) return 8'h81;
    return a[7:0] ^ {a[2:0], a[9:5]} ^ 8'h5A;
  endfunction

  assign font_data = rom(font_addr);

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic push_exp(input logic [3:0] c, input logic [11:0] a, input logic [1:0] b,
                          input logic [15:0] d, input bit last);
    exp_t e;
    e.cmd = c; e.a = a; e.b = b; e.d = d; e.last = last;
    expq.push_back(e);
  endtask

  // Expected command stream for one glyph; pause_row<0 means no pause
  task automatic build_glyph(input logic [6:0] col, input logic [6:0] row, input logic [6:0] code,
                             input logic [2:0] fg, input logic [2:0] bg, input int pause_row);
    logic [7:0]  bits;
    logic [15:0] clr;
    logic [2:0]  y3, x3;
`ifdef CHAR_BG_FILL_EN
    clr = {13'd0, bg};
`else
    clr = 16'd0;
    if (bg == 3'd7) clr = 16'd0;
`endif
    push_exp(PRE, 12'h400, col[6:5], 16'd0, 1'b0);
    for (int y = 0; y < 8; y++) begin
      y3 = 3'(y);
      bits = rom({code, y3});
      push_exp(ACT, {2'b00, row, y3}, col[6:5], 16'd0, 1'b0);
      for (int x = 0; x < 8; x++) begin
        x3 = 3'(x);
        push_exp(WRC, {4'b0000, col[4:0], x3}, col[6:5],
                 bits[7-x] ? {13'd0, fg} : clr, 1'b0);
      end
      push_exp(PRE, 12'h400, col[6:5], 16'd0, y == 7);
      if (y == pause_row) push_exp(PRE, 12'h400, col[6:5], 16'd0, 1'b0);
    end
  endtask

  // One-cycle request push, called #1 after a posedge
  task automatic applyStimulus(input logic [6:0] col, input logic [6:0] row, input logic [6:0] code,
                               input logic [2:0] fg, input logic [2:0] bg, input int pause_row,
                               output bit accepted);
    req_if.req_valid = 1'b1;
    req_if.req_col   = col;
    req_if.req_row   = row;
    req_if.req_code  = code;
    req_if.req_fg    = fg;
    req_if.req_bg    = bg;
    accepted = req_if.req_ready;
    @(posedge CLK);
    #1;
    req_if.req_valid = 1'b0;
    if (accepted) build_glyph(col, row, code, fg, bg, pause_row);
  endtask

  task automatic wait_idle(input int budget, output int cycles);
    cycles = 0;
    while (busy && cycles < budget) begin
      @(posedge CLK);
      #1;
      cycles++;
    end
    if (busy) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle_timeout: busy still 1 after %0d cycles, required 0", budget);
    end
    repeat (2) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic wait_write_row(input logic [2:0] gy, input int budget);
    int n = 0;
    bit hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge CLK);
      n++;
      hit = ({CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM} == WRC) && (font_addr[2:0] == gy);
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("[TB] FAIL write_timeout: no WRITE of row %0d within %0d cycles", gy, budget);
    end
  endtask

  // Monitor: compare every non-NOP command and glyph_done against the scoreboard
  always @(negedge CLK) begin
    if (!RSTn) begin
      prev_last = 1'b0;
    end else begin
      mon_cmd = {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM};
      if (glyph_done || prev_last) checkOutput("glyph_done", glyph_done, prev_last);
      if (glyph_done) done_cnt++;
      prev_last = 1'b0;
      if (mx_en_char || mon_cmd != NOP) checkOutput("mx_en_char", mx_en_char, mon_cmd != NOP);
      if (mon_cmd != NOP) begin
        nonnop++;
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_cmd: got %b A=%0h, required NOP", mon_cmd, A_SDRAM);
        end else begin
          mon_e = expq.pop_front();
          checkOutput("cmd", mon_cmd, mon_e.cmd);
          checkOutput("addr", A_SDRAM, mon_e.a);
          if (mon_e.cmd != PRE) checkOutput("bank", B_SDRAM, mon_e.b);
          if (mon_e.cmd == WRC) checkOutput("data", D_SDRAM, mon_e.d);
          prev_last = mon_e.last;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit acc;
    int n0, d0, cyc;
    req_if.req_valid = 1'b0;
    req_if.req_col = '0;
    req_if.req_row = '0;
    req_if.req_code = '0;
    req_if.req_fg = '0;
    req_if.req_bg = '0;

    // Reset state
    #12;
    checkOutput("rst_cmd", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM}, NOP);
    checkOutput("rst_addr", A_SDRAM, 0);
    checkOutput("rst_bank", B_SDRAM, 0);
    checkOutput("rst_data", D_SDRAM, 0);
    checkOutput("rst_mx", mx_en_char, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", glyph_done, 0);
    checkOutput("rst_ready", req_if.req_ready, 1);
    @(negedge CLK);
    RSTn = 1'b1;
    @(posedge CLK);
    #1;

    // Single glyph: col 33, row 5, code 0x41, fg 2, bg 5
    $display("[TB] single glyph");
    win_en = 1'b1;
    n0 = nonnop; d0 = done_cnt;
    applyStimulus(7'd33, 7'd5, 7'h41, 3'b010, 3'd5, -1, acc);
    checkOutput("single_accept", acc, 1);
    wait_idle(200, cyc);
    checkOutput("single_cycles", cyc, 82);
    checkOutput("single_nonnop", nonnop - n0, 81);
    checkOutput("single_done", done_cnt - d0, 1);

    // Back-pressure: fill FIFO with the window closed
    $display("[TB] back-pressure");
    win_en = 1'b0;
    n0 = nonnop; d0 = done_cnt;
    applyStimulus(7'd0,   7'd0,   7'h10, 3'd1, 3'd6, -1, acc);
    applyStimulus(7'd95,  7'd17,  7'h22, 3'd7, 3'd2, -1, acc);
    applyStimulus(7'd64,  7'd127, 7'h41, 3'd4, 3'd3, -1, acc);
    applyStimulus(7'd127, 7'd63,  7'h7F, 3'd5, 3'd0, -1, acc);
    checkOutput("full_ready", req_if.req_ready, 0);
    checkOutput("full_busy", busy, 1);
    checkOutput("closed_mx", mx_en_char, 0);
    applyStimulus(7'd9, 7'd9, 7'h09, 3'd1, 3'd1, -1, acc);
    checkOutput("fifth_rejected", acc, 0);
    win_en = 1'b1;
    wait_idle(1000, cyc);
    checkOutput("b2b_cycles", cyc, 328);
    checkOutput("bp_nonnop", nonnop - n0, 324);
    checkOutput("bp_done", done_cnt - d0, 4);

    // Pause during row 3
    $display("[TB] pause");
    n0 = nonnop; d0 = done_cnt;
    applyStimulus(7'd70, 7'd100, 7'h12, 3'd6, 3'd1, 3, acc);
    wait_write_row(3'd3, 400);
    win_en = 1'b0;
    cyc = 0;
    while (mx_en_char && cyc < 20) begin
      @(posedge CLK);
      #1;
      cyc++;
    end
    checkOutput("pause_mx_fell", mx_en_char, 0);
    repeat (5) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("pause_nop", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM}, NOP);
    checkOutput("pause_busy", busy, 1);
    win_en = 1'b1;
    wait_idle(400, cyc);
    checkOutput("pause_nonnop", nonnop - n0, 82);
    checkOutput("pause_done", done_cnt - d0, 1);

    // Simultaneous push and pop in the IDLE start cycle
    $display("[TB] push/pop same cycle");
    win_en = 1'b0;
    n0 = nonnop;
    applyStimulus(7'd2, 7'd1, 7'h03, 3'd3, 3'd4, -1, acc);
    win_en = 1'b1;
    applyStimulus(7'd40, 7'd2, 7'h41, 3'd2, 3'd5, -1, acc);
    checkOutput("pp_accept", acc, 1);
    applyStimulus(7'd41, 7'd3, 7'h05, 3'd1, 3'd2, -1, acc);
    applyStimulus(7'd42, 7'd4, 7'h06, 3'd7, 3'd3, -1, acc);
    applyStimulus(7'd43, 7'd5, 7'h07, 3'd6, 3'd1, -1, acc);
    checkOutput("pp_full_ready", req_if.req_ready, 0);
    wait_idle(1000, cyc);
    checkOutput("pp_nonnop", nonnop - n0, 405);

    // Reset mid-glyph discards the FIFO and idles outputs asynchronously
    $display("[TB] reset mid-glyph");
    win_en = 1'b0;
    applyStimulus(7'd10, 7'd20, 7'h30, 3'd5, 3'd2, -1, acc);
    applyStimulus(7'd11, 7'd21, 7'h31, 3'd4, 3'd2, -1, acc);
    win_en = 1'b1;
    wait_write_row(3'd2, 400);
    #2;
    RSTn = 1'b0;
    expq.delete();
    #1;
    checkOutput("amid_cmd", {CSn_SDRAM, RASn_SDRAM, CASn_SDRAM, WEn_SDRAM}, NOP);
    checkOutput("amid_mx", mx_en_char, 0);
    checkOutput("amid_busy", busy, 0);
    checkOutput("amid_ready", req_if.req_ready, 1);
    @(posedge CLK);
    #3;
    RSTn = 1'b1;
    repeat (50) begin
      @(posedge CLK);
      #1;
    end
    checkOutput("post_rst_busy", busy, 0);

    checkOutput("queue_empty", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sdram_char_writer.md
# sdram_char_writer

Queued glyph renderer that writes 8x8 font glyphs into the SDRAM frame buffer as foreground/background colour pixels. It works only while the timing generator marks the SDRAM bus as free (`win_en`). It replaces the single fixed-glyph writer with three additions:
- a request FIFO;
- per-request glyph code, position and colour;
- pause/resume across window closures.

It sits beside the VGA scan-out path and takes the SDRAM command bus through `mx_en_char`.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: request queue entries; power of two, at least 2.
- `CODE_W`, 7: glyph code width. The font ROM address is `CODE_W+3` bits.
- `COLOR_W`, 3: pixel colour width, at most 16.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` in 1: system/SDRAM clock.
- `RSTn` in 1: asynchronous active-low reset.
- `win_en` in 1: high while the SDRAM bus may be used by this block.
- `req_valid` in 1: a request is present.
- `req_ready` out 1: equals `!fifo_full`.
- `req_col` in 7: character column.
- `req_row` in 7: character row.
- `req_code` in `CODE_W`: glyph code.
- `req_fg` in `COLOR_W`: foreground colour.
- `req_bg` in `COLOR_W`: background colour.
- `font_addr` out `CODE_W+3`: `{code, gy}`, driven from registers.
- `font_data` in 8: glyph row bits, bit 7 is the leftmost pixel. The ROM must be asynchronous: data is valid in the same cycle as `font_addr`.
- `D_SDRAM` out 16: write data.
- `A_SDRAM` out 12: SDRAM address.
- `B_SDRAM` out 2: SDRAM bank.
- `CSn_SDRAM`, `RASn_SDRAM`, `CASn_SDRAM`, `WEn_SDRAM` out 1 each: the SDRAM command, `{CSn,RASn,CASn,WEn}`.
- `mx_en_char` out 1: bus grant request, high for every cycle this block drives a non-NOP command.
- `busy` out 1: high when the FIFO is non-empty or a glyph is active.
- `glyph_done` out 1: one-cycle pulse after the final precharge of a glyph.

## Operation
- **FIFO:**
  - Push on `req_valid & req_ready`.
  - Pop when IDLE starts a glyph; the head is latched into working registers `col`, `row`, `code`, `fg`, `bg`.
  - A push and a pop in the same cycle are both honoured, so the count is unchanged.
- **Commands:** NOP=1111, PRECHARGE=0010, ACTIVE=0011, WRITE=0100.
- **Address mapping for pixel (gx, gy):**
  - Bank: `B = col[6:5]`.
  - ACTIVE: `A = {2'b00, row, gy}`.
  - WRITE: `A = {4'b0000, col[4:0], gx}`.
  - Every PRECHARGE drives `A = 12'h400` (all banks).
- **Pixel and data:**
  - `pix = font_data[7-gx]`.
  - Pixel set: `D_SDRAM = fg`, zero-extended to 16 bits. Pixel clear: see Configuration.
- **States:**
  - IDLE
    - FIFO non-empty and `win_en` high: go to PRE0. Pop the head, set `gy=0`, raise `mx_en_char`.
    - Otherwise: stay in IDLE and issue NOP.
  - PRE0: PRECHARGE; go to ACT.
  - ACT: ACTIVE; clear `gx`; go to WR.
  - WR: WRITE pixel `gx`, then `gx++`. At `gx==7` go to PREN.
  - PREN: PRECHARGE, then `gy++`.
    - `gy==7`: pulse `glyph_done`, drop `mx_en_char`, go to IDLE.
    - Else, `win_en` low: drop `mx_en_char`, go to PAUSE.
    - Else: go to ACT.
  - PAUSE
    - NOP while `win_en` is low; `gy`, `code` and the working registers are held.
    - When `win_en` is high: raise `mx_en_char` and go to PRE0. The glyph resumes at row `gy`.
- **Window closure mid-row:** `win_en` falling while in ACT or WR does not abort the row. The row always completes through PREN, so no SDRAM row is ever left open.

## Timing
- **Reset values:** command NOP, `A_SDRAM=0`, `B_SDRAM=0`, `D_SDRAM=0`, `mx_en_char=0`, `busy=0`, `glyph_done=0`, state IDLE, FIFO empty, `req_ready=1`.
- **Glyph with no pause:** 1 PRE0, then 8 rows of (ACT + 8 WR + PREN) = 81 command cycles. `glyph_done` is asserted in the cycle after the final PREN.
- **Resume after a pause:** adds 1 PRE0 cycle.
- **SDRAM timing:** one command per cycle. tRCD and tRP are met by the system clock rate; this block inserts no wait states.
- **First command:** issued in the cycle after the IDLE decision; the FIFO head is popped in that same decision cycle.
- **Back-to-back glyphs:** with `win_en` high throughout, IDLE costs one NOP cycle between glyphs.
- **Asynchronous reset mid-glyph:** outputs return to reset values immediately; FIFO contents are discarded.

## Configuration
- `CHAR_BG_FILL_EN` defined: clear pixels are written with `D_SDRAM = bg`, zero-extended.
- `CHAR_BG_FILL_EN` undefined:
  - Clear pixels are written with `D_SDRAM = 0`.
  - The `req_bg` port remains but is ignored; no `bg` storage is built in the FIFO.
- Command count and timing are identical in both builds.

## Test plan
- **Single glyph:** reset, `win_en=1`, push col=33, row=5, code=0x41, fg=3'b010, with a ROM row of 0x81.
  - Exactly 81 non-NOP cycles.
  - First ACT: B=1, A=0x028. First WR: A=0x008, D=2. WR gx=1: D=bg or 0.
  - `glyph_done` pulses once.
- **Back-pressure:** with `win_en=0`, push 4 requests.
  - `req_ready` goes low after the 4th push; a 5th request is not accepted.
  - When `win_en` goes high, the 4 glyphs are written in push order.
- **Pause:** drop `win_en` during WR of row gy=3.
  - The row completes through PREN; `mx_en_char` falls; NOP while paused.
  - On `win_en` high: PRE0, then ACT with A low bits = 4.
- **Simultaneous push/pop:** FIFO holds 1 entry, push in the IDLE start cycle.
  - The count stays 1 and the pushed entry is processed next.
- **Reset mid-glyph:** `RSTn` low during WR.
  - NOP, `mx_en_char=0`, `busy=0` asynchronously; `req_ready=1`.
- **Macro build check:**
  - Without `CHAR_BG_FILL_EN`: bg=5 yields D=0 on clear pixels.
  - With it: D=5.
